vga_pattern_ctrl: RTL

UART-driven command controller for the VGA test-pattern pipeline, a successor to the fixed "low nibble selects pattern" scheme. Decodes single- and two-byte commands from the UART RX byte stream and returns ACK/NAK bytes to UART TX. Commands select a pattern, set a foreground colour and enable auto-cycling. All video-visible changes are applied only at a frame boundary. Sits between UART_RX/UART_TX and test_pattern.

---
 rtl/vga_pattern_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/vga_pattern_ctrl.sv
// vga_pattern_ctrl: UART command decoder that stages pattern/colour updates onto frame boundaries and optionally auto-cycles patterns.
module vga_pattern_ctrl #(
  parameter int VIDEO_WIDTH      = 3,
  parameter int NUM_PATTERNS     = 8,
  parameter int FRAMES_PER_STEP  = 60,
  parameter int ARG_TIMEOUT_CLKS = 2500000
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_rx_dv,
  input  logic [7:0]             i_rx_byte,
  input  logic                   i_tx_active,
  input  logic                   i_frame_start,
  output logic                   o_tx_dv,
  output logic [7:0]             o_tx_byte,
  output logic [3:0]             o_pattern,
  output logic [VIDEO_WIDTH-1:0] o_fg_r,
  output logic [VIDEO_WIDTH-1:0] o_fg_g,
  output logic [VIDEO_WIDTH-1:0] o_fg_b,
  output logic                   o_auto,
  output logic                   o_cmd_err
);
  localparam int TW = ARG_TIMEOUT_CLKS > 1 ? $clog2(ARG_TIMEOUT_CLKS) : 1;
  localparam int FW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [7:0] NAK = 8'hEE;
  typedef enum logic [1:0] {IDLE, WAIT_ARG, RESPOND} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_to_cnt;
  logic [FW-1:0] r_frame_cnt;
  logic [7:0] r_resp, r_tx_byte;
  logic r_tx_dv, r_cmd_err, r_pend, r_auto;
  logic [3:0] r_stg_pat, r_pattern, w_next_pat;
  logic [VIDEO_WIDTH-1:0] r_stg_r, r_stg_g, r_stg_b, r_fg_r, r_fg_g, r_fg_b;
  logic w_op_pat, w_op_auto, w_op_col, w_to_hit;
  logic w_idle_rx, w_arg_rx, w_timeout, w_nak, w_drop, w_tx_go;
  assign w_op_pat   = i_rx_byte[7:4] == 4'h0 && {1'b0, i_rx_byte[3:0]} < 5'(NUM_PATTERNS);
  assign w_op_auto  = i_rx_byte[7:4] == 4'h1 && i_rx_byte[3:1] == 3'b000;
  assign w_op_col   = i_rx_byte[7:4] == 4'h2 && i_rx_byte[3:0] < 4'd3;
  assign w_to_hit   = r_to_cnt == TW'(ARG_TIMEOUT_CLKS - 1);
  assign w_next_pat = r_pattern == 4'(NUM_PATTERNS - 1) ? 4'd0 : r_pattern + 4'd1;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE && i_rx_dv) w_next = w_op_col ? WAIT_ARG : RESPOND;
    else if (r_state == WAIT_ARG && (i_rx_dv || w_to_hit)) w_next = RESPOND;
    else if (r_state == RESPOND && !i_tx_active) w_next = IDLE;
  end
  always_comb begin
    w_idle_rx = r_state == IDLE && i_rx_dv;
    w_arg_rx  = r_state == WAIT_ARG && i_rx_dv;
    w_timeout = r_state == WAIT_ARG && !i_rx_dv && w_to_hit;
    w_nak     = (w_idle_rx && !(w_op_pat || w_op_auto || w_op_col)) || w_timeout;
    w_drop    = r_state == RESPOND && i_rx_dv;
    w_tx_go   = r_state == RESPOND && !i_tx_active;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_to_cnt    <= '0;
      r_frame_cnt <= '0;
      r_resp      <= '0;
      r_tx_byte   <= '0;
      r_tx_dv     <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_pend      <= 1'b0;
      r_auto      <= 1'b0;
      r_stg_pat   <= '0;
      r_pattern   <= '0;
      r_stg_r     <= '1;
      r_stg_g     <= '1;
      r_stg_b     <= '1;
      r_fg_r      <= '1;
      r_fg_g      <= '1;
      r_fg_b      <= '1;
    end else begin
      r_to_cnt  <= r_state == WAIT_ARG ? r_to_cnt + TW'(1) : '0;
      r_tx_dv   <= w_tx_go;
      r_cmd_err <= w_nak || w_drop;
      if (w_tx_go) r_tx_byte <= r_resp;
      if (w_idle_rx) r_resp <= w_nak ? NAK : i_rx_byte;
      if (w_timeout) r_resp <= NAK;
      // Frame boundary first so a same-cycle commit below overrides staging and pending for the next frame.
      if (i_frame_start && r_pend) begin
        r_pattern   <= r_stg_pat;
        r_fg_r      <= r_stg_r;
        r_fg_g      <= r_stg_g;
        r_fg_b      <= r_stg_b;
        r_pend      <= 1'b0;
        r_frame_cnt <= '0;
      end else if (i_frame_start && r_auto) begin
        if (r_frame_cnt == FW'(FRAMES_PER_STEP - 1)) begin
          r_frame_cnt <= '0;
          r_pattern   <= w_next_pat;
          r_stg_pat   <= w_next_pat;
        end else r_frame_cnt <= r_frame_cnt + FW'(1);
      end
      if (w_idle_rx && w_op_pat) begin
        r_stg_pat <= i_rx_byte[3:0];
        r_pend    <= 1'b1;
      end
      if (w_idle_rx && w_op_auto) begin
        r_auto <= i_rx_byte[0];
        if (i_rx_byte[0]) r_frame_cnt <= '0;
      end
      if (w_arg_rx) begin
        r_pend <= 1'b1;
        if (r_resp[1:0] == 2'd0) r_stg_r <= i_rx_byte[VIDEO_WIDTH-1:0];
        if (r_resp[1:0] == 2'd1) r_stg_g <= i_rx_byte[VIDEO_WIDTH-1:0];
        if (r_resp[1:0] == 2'd2) r_stg_b <= i_rx_byte[VIDEO_WIDTH-1:0];
      end
    end
  end
  assign o_tx_dv   = r_tx_dv;
  assign o_tx_byte = r_tx_byte;
  assign o_pattern = r_pattern;
  assign o_fg_r    = r_fg_r;
  assign o_fg_g    = r_fg_g;
  assign o_fg_b    = r_fg_b;
  assign o_auto    = r_auto;
  assign o_cmd_err = r_cmd_err;
endmodule
